freq_learn: RTL
===============

# freq_learn

Measures the frequency of a digitised input waveform, averages over several gate windows, snaps the result to the nominal tone set (1500/3000/4500 Hz) and presents it with a learn-done flag. Sits directly upstream of the seven-segment display driver: `freq_out` feeds its 16-bit value input and `learn_done` its learn-status input.

## Interface
- `GATE_CYCLES`, 50_000_000: sys_clk cycles per gate window (1 s at 50 MHz, so the count is in Hz).
- `N_AVG`, 4: windows averaged per learn; power of two, 1..16.
- `TOL`, 50: snap tolerance in Hz.
- `sys_clk` in 1: system clock, 50 MHz.
- `sys_rst_n` in 1: reset, asynchronous, active-low.
- `sig_in` in 1: comparator output; asynchronous to sys_clk.
- `learn_start` in 1: one-cycle start pulse from the debounced key.
- `freq_out` out 16: learned frequency in Hz.
- `freq_valid` out 1: one-cycle pulse when `freq_out` updates.
- `learn_done` out 1: level; high from result until next start.
- `busy` out 1: high while measuring.

## Operation
- `sig_in` goes through a 2-FF synchroniser and then a rising-edge detector on the synchronised signal.
- FSM states:
  - IDLE: waits for `learn_start`.
  - MEAS: gate counter runs 0..GATE_CYCLES-1; each detected edge increments the edge counter.
  - ACC: one cycle; adds the window count to the accumulator and increments the window index.
  - CALC: one cycle; computes the average and snaps it.
  - DONE: one cycle; updates outputs, then returns to IDLE.
- Transitions:
  - IDLE→MEAS on `learn_start`. Clears gate counter, edge counter, accumulator and window index, and drops `learn_done`.
  - MEAS→ACC when the gate counter reaches GATE_CYCLES-1. An edge on that last cycle is counted.
  - ACC→MEAS if window index < N_AVG after the increment. The edge counter is cleared.
  - ACC→CALC otherwise.
  - CALC→DONE→IDLE.
- Arithmetic:
  - Edge counter is 16 bits and saturates at 65535.
  - Accumulator is 16+log2(N_AVG) bits.
  - Average = accumulator >> log2(N_AVG), truncating.
- Snap: if |avg−1500| ≤ TOL, output 1500; likewise for 3000 and 4500. Otherwise output the raw average.
- `learn_start` while busy (MEAS/ACC/CALC) aborts and restarts from clean counters. `freq_out` holds its old value and `learn_done` stays 0.
- `learn_start` in DONE is ignored. It is accepted in IDLE.
- Zero edges gives `freq_out` = 0; this is still a valid learn.

## Timing
- Reset values: `freq_out` = 0, `freq_valid` = 0, `learn_done` = 0, `busy` = 0, state IDLE. All internal counters are 0.
- Input latency is 2 cycles (synchroniser) plus 1 cycle (edge detect) before an edge is counted. Edges arriving after the window closes are not carried into the next window.
- `busy` is high from the cycle after `learn_start` until the cycle state leaves CALC.
- One learn takes N_AVG×(GATE_CYCLES+1)+2 cycles from the `learn_start` cycle to the `freq_valid` cycle.
- In the `freq_valid` cycle, `freq_out` and `learn_done` both update; `learn_done` rises in the same cycle.
- `learn_done` falls the cycle after an accepted `learn_start`.
- Input edges arriving faster than sys_clk/2 are undercounted; this is out of spec.
- Async reset mid-learn returns everything to reset values immediately.

## Structure
- Shared package holds:
  - Nominal constants F_LO = 1500, F_MID = 3000, F_HI = 4500.
  - The FSM state enum.
  - A log2 helper function.
- One sub-module, `edge_sync`: 2-FF synchroniser plus rising-edge pulse. It is reusable for other asynchronous inputs.
- The top module holds the FSM, counters, accumulator and snap logic.

## Test plan
Use GATE_CYCLES = 1000 and N_AVG = 4 for simulation.
- **Reset:** assert reset mid-MEAS → all outputs 0 within one cycle and state IDLE; after release, no activity until `learn_start`.
- **Exact edge count:** 15 edges per window, ideal spacing → `freq_out` = 15, `freq_valid` pulses once, `learn_done` = 1. Total latency equals 4×1001+2 cycles.
- **Snap:** with TOL = 50, drive window counts 1480, 1520, 1490, 1510 (average 1500) → `freq_out` = 1500. Drive counts averaging 3049 → 3000. Drive counts averaging 2940 → 2940 (outside tolerance, raw value).
- **Abort:** second `learn_start` during window 2 → `learn_done` stays 0 and the old `freq_out` is held. The result reflects only the windows after the restart.
- **Gate boundary:** an edge on the last gate cycle is counted. An edge landing one cycle after the window closes is not counted in either window.
- **Saturation / zero:** no edges → `freq_out` = 0 with `learn_done` = 1. An over-range forced count saturates the edge counter at 65535 with no wrap.

Source files
------------

// File: rtl/freq_learn_pkg.sv
// -----------------------------------------------------------------------------
// freq_learn_pkg
// Shared definitions for the frequency-learn block:
//   - nominal tone frequencies the learned value snaps to
//   - FSM state encoding (also exported on the top's dbg_state port)
//   - log2 helper used to size the accumulator and the gate counter
//   - tolerance-window test used by the snap logic
// -----------------------------------------------------------------------------
package freq_learn_pkg;

  localparam int F_LO  = 1500;
  localparam int F_MID = 3000;
  localparam int F_HI  = 4500;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MEAS = 3'd1,
    ST_ACC  = 3'd2,
    ST_CALC = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Smallest r with 2**r >= value (0 for value <= 1).
  function automatic int log2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // True when v lies within +/- tol of nom (inclusive).
  function automatic logic near_nominal(input logic [15:0] v, input int nom, input int tol);
    int d;
    d = int'(v) - nom;
    if (d < 0) d = -d;
    return (d <= tol);
  endfunction

endpackage

// File: rtl/freq_learn_edge_sync.sv
// -----------------------------------------------------------------------------
// edge_sync
// Brings an asynchronous input into the sys_clk domain through two flops and
// produces a one-cycle registered pulse on each rising edge of the
// synchronised level. Latency from input change to pulse is 3 cycles.
// Ports:
//   sys_clk    in  system clock
//   sys_rst_n  in  asynchronous active-low reset
//   async_in   in  asynchronous level input
//   rise_pulse out one-cycle pulse per rising edge of async_in
// -----------------------------------------------------------------------------
module edge_sync (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic sync_1;
  logic sync_2;
  logic sync_2_d;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      sync_2_d   <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_1     <= async_in;
      sync_2     <= sync_1;
      sync_2_d   <= sync_2;
      rise_pulse <= sync_2 & ~sync_2_d;
    end
  end

endmodule

// File: rtl/freq_learn.sv
// -----------------------------------------------------------------------------
// freq_learn
// Counts rising edges of sig_in over N_AVG gate windows of GATE_CYCLES each,
// averages the window counts, snaps the average to the nearest nominal tone
// (1500/3000/4500 Hz) when within TOL, and presents the result.
// Ports:
//   sys_clk     in      system clock
//   sys_rst_n   in      asynchronous active-low reset
//   sig_in      in      comparator output, asynchronous to sys_clk
//   learn_start in      one-cycle start pulse (restarts a learn in progress)
//   freq_out    out[16] learned frequency
//   freq_valid  out     one-cycle pulse in the cycle freq_out updates
//   learn_done  out     level, high from result until the next accepted start
//   busy        out     high while a learn is in progress
//   dbg_state   out[3]  current FSM state (freq_learn_pkg::state_t encoding)
//
// freq_valid is a pure qualifier with no backpressure: the consumer must take
// freq_out in the cycle freq_valid is high; freq_out then holds until the next
// completed learn.
// -----------------------------------------------------------------------------
module freq_learn
  import freq_learn_pkg::*;
#(
  parameter int GATE_CYCLES = 50_000_000,
  parameter int N_AVG       = 4,
  parameter int TOL         = 50
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        sig_in,
  input  logic        learn_start,
  output logic [15:0] freq_out,
  output logic        freq_valid,
  output logic        learn_done,
  output logic        busy,
  output logic [2:0]  dbg_state
);

  localparam int AVG_SH   = log2_ceil(N_AVG);
  localparam int ACC_W    = 16 + AVG_SH;
  localparam int GATE_L2  = log2_ceil(GATE_CYCLES);
  localparam int GATE_W   = (GATE_L2 < 1) ? 1 : GATE_L2;
  localparam int WIN_W    = AVG_SH + 1;

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(N_AVG - 1);

  state_t            state;
  logic [GATE_W-1:0] gate_cnt;
  logic [15:0]       edge_cnt;
  logic [ACC_W-1:0]  acc;
  logic [WIN_W-1:0]  win_idx;

  logic              edge_pulse;
  logic [15:0]       avg;
  logic [15:0]       snapped;
  logic              start_ok;

  edge_sync u_edge_sync (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .async_in   (sig_in),
    .rise_pulse (edge_pulse)
  );

  // Dividing by a power of two: drop the low AVG_SH bits (truncating).
  assign avg = acc[ACC_W-1:AVG_SH];

  always_comb begin
    snapped = avg;
    if (near_nominal(avg, F_LO, TOL))       snapped = 16'(F_LO);
    else if (near_nominal(avg, F_MID, TOL)) snapped = 16'(F_MID);
    else if (near_nominal(avg, F_HI, TOL))  snapped = 16'(F_HI);
  end

  // A start is honoured everywhere except in DONE, where the result is being
  // presented for its single cycle.
  assign start_ok = learn_start && (state != ST_DONE);

  assign dbg_state = state;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      gate_cnt   <= '0;
      edge_cnt   <= '0;
      acc        <= '0;
      win_idx    <= '0;
      freq_out   <= '0;
      freq_valid <= 1'b0;
      learn_done <= 1'b0;
      busy       <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (start_ok) begin
        // Fresh start or abort-and-restart: freq_out keeps the last result.
        state      <= ST_MEAS;
        gate_cnt   <= '0;
        edge_cnt   <= '0;
        acc        <= '0;
        win_idx    <= '0;
        learn_done <= 1'b0;
        busy       <= 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            state <= ST_IDLE;
          end
          ST_MEAS: begin
            // Edge on the final gate cycle is still counted.
            if (edge_pulse && (edge_cnt != 16'hFFFF)) edge_cnt <= edge_cnt + 16'd1;
            if (gate_cnt == GATE_LAST) state <= ST_ACC;
            else                       gate_cnt <= gate_cnt + GATE_W'(1);
          end
          ST_ACC: begin
            // Edges seen during this cycle are dropped, not carried over.
            acc     <= acc + ACC_W'(edge_cnt);
            win_idx <= win_idx + WIN_W'(1);
            if (win_idx == WIN_LAST) begin
              state <= ST_CALC;
            end else begin
              state    <= ST_MEAS;
              gate_cnt <= '0;
              edge_cnt <= '0;
            end
          end
          ST_CALC: begin
            freq_out   <= snapped;
            freq_valid <= 1'b1;
            learn_done <= 1'b1;
            busy       <= 1'b0;
            state      <= ST_DONE;
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
